// File: rtl/acc_mul2b.sv
// Multiply-accumulate back end: sums N_TERMS 4-bit products per run.
// Define ACC_MUL2B_SAT_EN to clamp acc on overflow instead of wrapping.
module acc_mul2b #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 8,
    localparam int CNT_W  = $clog2(N_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       z,
    input  logic             z_valid,
    output logic             ready,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] acc_nxt;
    logic             last;

    assign sum     = {1'b0, acc} + {{(ACC_W - 3){1'b0}}, z};
    assign sum_ovf = sum[ACC_W];
    assign last    = (count == CNT_W'(N_TERMS - 1));
    assign ready   = (state == RUN);
    assign done    = (state == DONE);

`ifdef ACC_MUL2B_SAT_EN
    assign acc_nxt = sum_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    // start outranks a simultaneous accept, so that term is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (start) begin
            state <= RUN;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: state <= IDLE;
                RUN: begin
                    if (z_valid) begin
                        acc   <= acc_nxt;
                        count <= count + 1'b1;
                        if (sum_ovf)
                            ovf <= 1'b1;
                        if (last)
                            state <= DONE;
                    end
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_mul2b.sv
// Bench for acc_mul2b: default instance plus ACC_W=4/N_TERMS=3 instance,
// checked each cycle against an integer reference model.
module tb_acc_mul2b;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] z = '0;
    logic       z_valid = 1'b0;

    logic       rdy0, done0, ovf0;
    logic [7:0] acc0;
    logic [2:0] cnt0;
    logic       rdy1, done1, ovf1;
    logic [3:0] acc1;
    logic [1:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    int m_acc[2];
    int m_cnt[2];
    bit m_ovf[2];
    bit m_run[2];
    bit m_done[2];
    int nt[2] = '{4, 3};
    int aw[2] = '{8, 4};

    always #5 clk = ~clk;

    acc_mul2b u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .z(z), .z_valid(z_valid), .ready(rdy0),
        .acc(acc0), .count(cnt0), .done(done0), .ovf(ovf0)
    );

    acc_mul2b #(.N_TERMS(3), .ACC_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .z(z), .z_valid(z_valid), .ready(rdy1),
        .acc(acc1), .count(cnt1), .done(done1), .ovf(ovf1)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input int i);
        int s;
        int mx;
        mx = (1 << aw[i]) - 1;
        if (rst) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
            m_run[i] = 0; m_done[i] = 0;
        end else if (start) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
            m_run[i] = 1; m_done[i] = 0;
        end else if (m_run[i] && z_valid) begin
            s = m_acc[i] + int'(z);
            if (s > mx) begin
                m_ovf[i] = 1;
`ifdef ACC_MUL2B_SAT_EN
                s = mx;
`else
                s = s % (mx + 1);
`endif
            end
            m_acc[i] = s;
            m_cnt[i]++;
            if (m_cnt[i] == nt[i]) begin
                m_run[i] = 0;
                m_done[i] = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("rdy0", 32'(rdy0), 32'(m_run[0]));
        check("done0", 32'(done0), 32'(m_done[0]));
        check("acc0", 32'(acc0), 32'(m_acc[0]));
        check("cnt0", 32'(cnt0), 32'(m_cnt[0]));
        check("ovf0", 32'(ovf0), 32'(m_ovf[0]));
        check("rdy1", 32'(rdy1), 32'(m_run[1]));
        check("done1", 32'(done1), 32'(m_done[1]));
        check("acc1", 32'(acc1), 32'(m_acc[1]));
        check("cnt1", 32'(cnt1), 32'(m_cnt[1]));
        check("ovf1", 32'(ovf1), 32'(m_ovf[1]));
    endtask

    task automatic cyc(input logic r, input logic s,
                       input logic v, input logic [3:0] zz);
        rst = r; start = s; z_valid = v; z = zz;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    initial begin
        int nom[4];
        int gap[7];
        int wexp[3];
        nom = '{9, 6, 4, 1};
        gap = '{1, 0, 0, 1, 1, 0, 1};
`ifdef ACC_MUL2B_SAT_EN
        wexp = '{9, 15, 15};
`else
        wexp = '{9, 2, 3};
`endif
        #2;
        // reset with start and z_valid held high
        cyc(1, 1, 1, 4'd7);
        cyc(1, 1, 1, 4'd7);
        check("rst_acc", 32'(acc0), 0);
        check("rst_rdy", 32'(rdy0), 0);
        cyc(0, 0, 0, 4'd0);
        check("idle_rdy", 32'(rdy0), 0);

        // nominal run
        cyc(0, 1, 0, 4'd0);
        check("nom_rdy", 32'(rdy0), 1);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 4'(nom[k]));
            if (k == 0) check("nom_a0", 32'(acc0), 9);
            if (k == 1) check("nom_a1", 32'(acc0), 15);
            if (k == 2) check("nom_a2", 32'(acc0), 19);
            if (k == 3) check("nom_a3", 32'(acc0), 20);
        end
        check("nom_done", 32'(done0), 1);
        check("nom_rdy0", 32'(rdy0), 0);
        check("nom_ovf", 32'(ovf0), 0);

        // gapped handshake
        cyc(0, 1, 0, 4'd3);
        for (int k = 0; k < 7; k++)
            cyc(0, 0, 1'(gap[k]), 4'd3);
        check("gap_acc", 32'(acc0), 12);
        check("gap_done", 32'(done0), 1);

        // wrap/saturate on the narrow instance
        cyc(0, 1, 0, 4'd0);
        cyc(0, 0, 1, 4'd9);
        check("w_a0", 32'(acc1), 32'(wexp[0]));
        check("w_ovf0", 32'(ovf1), 0);
        cyc(0, 0, 1, 4'd9);
        check("w_a1", 32'(acc1), 32'(wexp[1]));
        check("w_ovf1", 32'(ovf1), 1);
        cyc(0, 0, 1, 4'd1);
        check("w_a2", 32'(acc1), 32'(wexp[2]));
        check("w_ovf2", 32'(ovf1), 1);
        check("w_done", 32'(done1), 1);

        // restart mid-run, then ignored input in DONE
        cyc(0, 1, 0, 4'd0);
        cyc(0, 0, 1, 4'd1);
        cyc(0, 0, 1, 4'd1);
        cyc(0, 1, 1, 4'd5);
        check("rs_acc", 32'(acc0), 0);
        check("rs_cnt", 32'(cnt0), 0);
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 1, 4'd2);
        check("rs_acc8", 32'(acc0), 8);
        cyc(0, 0, 1, 4'd2);
        check("dn_acc", 32'(acc0), 8);
        check("dn_done", 32'(done0), 1);

        // reset mid-run
        cyc(0, 1, 0, 4'd0);
        cyc(0, 0, 1, 4'd4);
        cyc(1, 1, 1, 4'd4);
        check("mr_acc", 32'(acc0), 0);
        check("mr_rdy", 32'(rdy0), 0);

        // random traffic
        for (int k = 0; k < 2000; k++)
            cyc(1'($urandom_range(63) == 0),
                1'($urandom_range(15) == 0),
                1'($urandom_range(1)),
                4'($urandom_range(15)));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
